dm_csr_access: RTL and testbench



---
 rtl/dm_csr_access.sv | 196 +++++++++++++++++++
 tb/tb_dm_csr_access.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_csr_access.sv
// dm_csr_access: debug-module initiator for the hart CSR access port.
// Takes one abstract CSR command at a time. It waits for the CSR port grant,
// reads the old value, and may then write it back using swap, set or clear.
// It returns the old value and a status on the response channel.

package config_pkg;
    localparam int XLEN = 32;
endpackage

module dm_csr_access #(
    parameter int XLEN    = config_pkg::XLEN,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CmdValid,
    output logic            CmdReady,
    input  logic [1:0]      CmdOp,
    input  logic [11:0]     CmdAdr,
    input  logic [XLEN-1:0] CmdData,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [XLEN-1:0] RspData,
    output logic [1:0]      RspStatus,
    output logic            CSRReqM,
    input  logic            CSRGrantM,
    output logic [11:0]     CSRAdrM,
    output logic            CSRWriteM,
    output logic [XLEN-1:0] CSRWriteValM,
    input  logic [XLEN-1:0] CSRReadValM,
    input  logic            IllegalCSRAccessM
);

    // Counter sized to hold TIMEOUT; one bit when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLR   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ILLEGAL = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } status_t;

    state_t            state_q,  state_d;
    op_t               op_q,     op_d;
    logic [11:0]       adr_q,    adr_d;
    logic [XLEN-1:0]   data_q,   data_d;
    logic [XLEN-1:0]   wval_q,   wval_d;
    logic [XLEN-1:0]   rdata_q,  rdata_d;
    status_t           status_q, status_d;
    logic [CW-1:0]     cnt_q,    cnt_d;

    assign RspData   = rdata_q;
    assign RspStatus = status_q;

    // Next-state, datapath updates and port outputs for the command sequencer.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        adr_d        = adr_q;
        data_d       = data_q;
        wval_d       = wval_q;
        rdata_d      = rdata_q;
        status_d     = status_q;
        cnt_d        = cnt_q;
        CmdReady     = 1'b0;
        RspValid     = 1'b0;
        CSRReqM      = 1'b0;
        CSRAdrM      = '0;
        CSRWriteM    = 1'b0;
        CSRWriteValM = '0;

        case (state_q)
            S_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) begin
                    op_d    = op_t'(CmdOp);
                    adr_d   = CmdAdr;
                    data_d  = CmdData;
                    cnt_d   = '0;
                    state_d = S_ARB;
                end
            end

            S_ARB: begin
                CSRReqM = 1'b1;
                CSRAdrM = adr_q;
                if (CSRGrantM) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    if ((TIMEOUT != 0) && (cnt_d == TO_VAL)) begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        state_d  = S_RESP;
                    end
                end
            end

            S_READ: begin
                CSRReqM = 1'b1;
                CSRAdrM = adr_q;
                rdata_d = CSRReadValM;
                if (!CSRGrantM) begin
                    status_d = ST_ABORT;
                    state_d  = S_RESP;
                end else if (IllegalCSRAccessM) begin
                    status_d = ST_ILLEGAL;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end else if (op_q == OP_READ) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if ((op_q != OP_WRITE) && (data_q == '0)) begin
                    // Set/clear with an empty mask cannot change the CSR; skip the write.
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else begin
                    case (op_q)
                        OP_SET:  wval_d = CSRReadValM | data_q;
                        OP_CLR:  wval_d = CSRReadValM & ~data_q;
                        default: wval_d = data_q;
                    endcase
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                CSRReqM      = 1'b1;
                CSRAdrM      = adr_q;
                CSRWriteValM = wval_q;
                CSRWriteM    = CSRGrantM & ~IllegalCSRAccessM;
                if (!CSRGrantM) begin
                    status_d = ST_ABORT;
                end else if (IllegalCSRAccessM) begin
                    status_d = ST_ILLEGAL;
                end else begin
                    status_d = ST_OK;
                end
                state_d = S_RESP;
            end

            S_RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_READ;
            adr_q    <= '0;
            data_q   <= '0;
            wval_q   <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            wval_q   <= wval_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_csr_access.sv
// Testbench for dm_csr_access. A transaction-level model predicts each
// command's latency, write activity and response. A negedge monitor checks
// the DUT against that prediction on every active cycle.

module tb_dm_csr_access;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            CmdValid;
    logic            CmdReady;
    logic [1:0]      CmdOp;
    logic [11:0]     CmdAdr;
    logic [XLEN-1:0] CmdData;
    logic            RspValid;
    logic            RspReady;
    logic [XLEN-1:0] RspData;
    logic [1:0]      RspStatus;
    logic            CSRReqM;
    logic            CSRGrantM;
    logic [11:0]     CSRAdrM;
    logic            CSRWriteM;
    logic [XLEN-1:0] CSRWriteValM;
    logic [XLEN-1:0] CSRReadValM;
    logic            IllegalCSRAccessM;

    always #5 clk = ~clk;

    dm_csr_access #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .CmdValid          (CmdValid),
        .CmdReady          (CmdReady),
        .CmdOp             (CmdOp),
        .CmdAdr            (CmdAdr),
        .CmdData           (CmdData),
        .RspValid          (RspValid),
        .RspReady          (RspReady),
        .RspData           (RspData),
        .RspStatus         (RspStatus),
        .CSRReqM           (CSRReqM),
        .CSRGrantM         (CSRGrantM),
        .CSRAdrM           (CSRAdrM),
        .CSRWriteM         (CSRWriteM),
        .CSRWriteValM      (CSRWriteValM),
        .CSRReadValM       (CSRReadValM),
        .IllegalCSRAccessM (IllegalCSRAccessM)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome of the command in flight
    logic [XLEN-1:0] exp_data;
    logic [XLEN-1:0] exp_wval;
    logic [1:0]      exp_status;
    logic [11:0]     exp_adr;
    int              exp_lat;
    int              exp_wr;

    // Observations kept for literal spot checks
    logic [XLEN-1:0] last_rsp_data;
    logic [XLEN-1:0] last_wval;

    function automatic logic [XLEN-1:0] new_value(input logic [1:0] op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] d);
        case (op)
            2'd1:    return d;
            2'd2:    return old | d;
            2'd3:    return old & ~d;
            default: return old;
        endcase
    endfunction

    // arb_wait: ARB cycles without grant before grant rises (-1 = never);
    // drop=2: grant removed during the write cycle.
    task automatic set_expect(input logic [1:0] op, input logic [11:0] adr,
                              input logic [XLEN-1:0] d, input logic [XLEN-1:0] old,
                              input logic ill, input int arb_wait, input int drop);
        bit needs_wr;
        needs_wr = (op == 2'd1) || ((op != 2'd0) && (d != '0));
        exp_adr  = adr;
        exp_wval = new_value(op, old, d);
        exp_wr   = 0;
        if (arb_wait < 0 || arb_wait >= TO) begin
            exp_status = 2'd2; exp_data = '0;  exp_lat = TO + 1;
        end else if (ill) begin
            exp_status = 2'd1; exp_data = '0;  exp_lat = arb_wait + 3;
        end else if (!needs_wr) begin
            exp_status = 2'd0; exp_data = old; exp_lat = arb_wait + 3;
        end else if (drop == 2) begin
            exp_status = 2'd3; exp_data = old; exp_lat = arb_wait + 4;
        end else begin
            exp_status = 2'd0; exp_data = old; exp_lat = arb_wait + 4; exp_wr = 1;
        end
    endtask

    // Monitor: cycle 0 is the accept cycle; checks every cycle until back in IDLE.
    bit active = 0;
    bit rsp_seen = 0;
    int cyc = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            active   = 0;
            rsp_seen = 0;
        end else begin
            if (active && rsp_seen && !RspValid) begin
                chk("ready_after_rsp", CmdReady, 1);
                active = 0;
            end else if (active) begin
                cyc++;
                chk("cmdready_busy", CmdReady, 0);
                if (CSRReqM) chk("csr_adr", CSRAdrM, exp_adr);
                if (CSRWriteM) begin
                    wr_cnt++;
                    last_wval = CSRWriteValM;
                    chk("write_val", CSRWriteValM, exp_wval);
                end
                if (RspValid) begin
                    if (!rsp_seen) begin
                        rsp_seen = 1;
                        last_rsp_data = RspData;
                        chk("latency", cyc, exp_lat);
                        chk("write_count", wr_cnt, exp_wr);
                    end
                    chk("rsp_data", RspData, exp_data);
                    chk("rsp_status", RspStatus, exp_status);
                    chk("req_in_resp", CSRReqM, 0);
                end
            end else if (CSRWriteM) begin
                chk("stray_write", CSRWriteM, 0);
            end
            if (!active && CmdValid && CmdReady) begin
                active   = 1;
                rsp_seen = 0;
                cyc      = 0;
                wr_cnt   = 0;
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [11:0] adr,
                           input logic [XLEN-1:0] d, input logic [XLEN-1:0] old,
                           input logic ill, input int arb_wait, input int drop,
                           input int rsp_delay);
        int c;
        int rcnt;
        bit in_rsp;
        bit done;
        set_expect(op, adr, d, old, ill, arb_wait, drop);
        @(posedge clk); #1;
        CSRReadValM       = old;
        IllegalCSRAccessM = ill;
        CmdOp    = op;
        CmdAdr   = adr;
        CmdData  = d;
        CmdValid = 1'b1;
        RspReady = 1'b0;
        CSRGrantM = (arb_wait >= 0) && (arb_wait < 1);
        @(posedge clk); #1;
        CmdValid = 1'b0;
        c = 1; rcnt = 0; in_rsp = 0; done = 0;
        while (!done && c < 200) begin
            CSRGrantM = (arb_wait >= 0) && (c > arb_wait) &&
                        !((drop == 2) && (c == arb_wait + 3));
            if (RspValid) begin
                in_rsp   = 1;
                RspReady = (rcnt >= rsp_delay);
                rcnt++;
            end else if (in_rsp) begin
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                c++;
            end
        end
        chk("rsp_completed", done, 1);
        CSRGrantM = 1'b0;
        RspReady  = 1'b0;
        IllegalCSRAccessM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdAdr = '0; CmdData = '0;
        RspReady = 1'b0; CSRGrantM = 1'b0; CSRReadValM = '0; IllegalCSRAccessM = 1'b0;
        last_rsp_data = '0; last_wval = '0;
        #1;
        chk("rst_cmdready", CmdReady, 1);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_rspdata", RspData, 0);
        chk("rst_rspstatus", RspStatus, 0);
        chk("rst_req", CSRReqM, 0);
        chk("rst_write", CSRWriteM, 0);
        chk("rst_adr", CSRAdrM, 0);
        chk("rst_wval", CSRWriteValM, 0);
        #12 reset = 1'b1;

        // Model pins
        chk("model_set_lit", new_value(2'd2, 32'h2, 32'h20), 32'h22);
        chk("model_clr_lit", new_value(2'd3, 32'hFF, 32'h0F), 32'hF0);

        // 1: plain read
        run_cmd(2'd0, 12'h141, 32'h0, 32'h8000_0040, 0, 0, 0, 0);
        chk("t1_data_lit", last_rsp_data, 32'h8000_0040);
        // 2: set, empty clear, clear, delayed-grant swap, swap of zero
        run_cmd(2'd2, 12'h100, 32'h20, 32'h2, 0, 0, 0, 0);
        chk("t2_wval_lit", last_wval, 32'h22);
        run_cmd(2'd3, 12'h100, 32'h0, 32'h22, 0, 0, 0, 0);
        run_cmd(2'd3, 12'h300, 32'h0F, 32'hFF, 0, 0, 0, 1);
        run_cmd(2'd1, 12'h340, 32'hDEAD_BEEF, 32'h1234, 0, 2, 0, 0);
        run_cmd(2'd1, 12'h341, 32'h0, 32'h5A5A, 0, 0, 0, 0);
        // 3: illegal access found during read
        run_cmd(2'd1, 12'h180, 32'h1, 32'h77, 1, 0, 0, 0);
        // 4: timeout, and grant arriving in the last ARB cycle
        run_cmd(2'd0, 12'h7B0, 32'h0, 32'h99, 0, -1, 0, 0);
        run_cmd(2'd0, 12'h7B1, 32'h0, 32'h55, 0, TO - 1, 0, 0);
        // 5: grant drops in the write cycle, slow response consumer
        run_cmd(2'd2, 12'h305, 32'h10, 32'h1, 0, 0, 2, 5);

        // 6: asynchronous reset in the middle of the write cycle
        @(posedge clk); #1;
        set_expect(2'd1, 12'h3A0, 32'h77, 32'h11, 0, 0, 0);
        CSRReadValM = 32'h11; CmdOp = 2'd1; CmdAdr = 12'h3A0; CmdData = 32'h77;
        CmdValid = 1'b1; CSRGrantM = 1'b1;
        @(posedge clk); #1;
        CmdValid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t6_write_before_rst", CSRWriteM, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_write", CSRWriteM, 0);
        chk("t6_cmdready", CmdReady, 1);
        chk("t6_rspvalid", RspValid, 0);
        chk("t6_rspdata", RspData, 0);
        chk("t6_req", CSRReqM, 0);
        chk("t6_adr", CSRAdrM, 0);
        chk("t6_wval", CSRWriteValM, 0);
        #4 reset = 1'b1;
        CSRGrantM = 1'b0;
        run_cmd(2'd0, 12'h7C0, 32'h0, 32'hA5A5, 0, 0, 0, 0);
        run_cmd(2'd2, 12'h7C1, 32'h0F00, 32'h00F0, 0, 1, 0, 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
